fe_redirect_fetch_unit: RTL and testbench

//  Fetch-side consumer of the AGEX->FE branch-redirect bus {new_branch_PC, br_cond}.

---
 rtl/fe_redirect_fetch_unit.sv | 81 ++++++++
 tb/tb_fe_redirect_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fe_redirect_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads instruction memory and fills the FE->DE latch,
// squashing the wrong path with a one-cycle bubble when AGEX redirects.
module fe_redirect_fetch_unit #(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned INSTBITS = 32,
    parameter int unsigned IMEMADDR = 14,
    parameter logic [DBITS-1:0]    START_PC = 32'h0000_0200,
    parameter logic [INSTBITS-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                br_cond_in,
    input  logic [DBITS-1:0]    br_target_in,
    input  logic                stall_in,
    output logic [IMEMADDR-1:0] imem_addr,
    input  logic [INSTBITS-1:0] imem_rdata,
    output logic                fe_valid,
    output logic [INSTBITS-1:0] fe_inst,
    output logic [DBITS-1:0]    fe_pc,
    output logic [DBITS-1:0]    fe_pcplus,
    output logic [DBITS-1:0]    fe_inst_count,
    output logic                misalign_err,
    output logic [15:0]         redirect_count
);

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [DBITS-1:0] pc_q;
    logic [DBITS-1:0] count_q;
    logic [DBITS-1:0] pc_plus4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DBITS-1:0] align_word(input logic [DBITS-1:0] v);
        return {v[DBITS-1:2], 2'b00};
    endfunction

    assign pc_plus4  = pc_q + DBITS'(4);
    assign imem_addr = pc_q[IMEMADDR+1:2];

    // Fetch PC / FE latch update: reset > redirect > stall > advance
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BOOT;
            pc_q           <= START_PC;
            count_q        <= '0;
            fe_valid       <= 1'b0;
            fe_inst        <= NOP_INST;
            fe_pc          <= '0;
            fe_pcplus      <= '0;
            fe_inst_count  <= '0;
            misalign_err   <= 1'b0;
            redirect_count <= '0;
        end else if (br_cond_in) begin
            state          <= RUN;
            pc_q           <= align_word(br_target_in);
            fe_valid       <= 1'b0;
            fe_inst        <= NOP_INST;
            redirect_count <= sat_inc16(redirect_count);
            if (br_target_in[1:0] != 2'b00)
                misalign_err <= 1'b1;
        end else if (state == BOOT) begin
            // The imem read for START_PC is not trusted in the cycle reset drops.
            state    <= RUN;
            fe_valid <= 1'b0;
        end else if (!stall_in) begin
            fe_valid      <= 1'b1;
            fe_inst       <= imem_rdata;
            fe_pc         <= pc_q;
            fe_pcplus     <= pc_plus4;
            fe_inst_count <= count_q;
            pc_q          <= pc_plus4;
            count_q       <= count_q + DBITS'(1);
        end
    end

endmodule

// File: tb/tb_fe_redirect_fetch_unit.sv
// Directed bench for fe_redirect_fetch_unit: vector table for the main flow plus
// hand-written reset-mid-redirect and redirect-counter saturation sequences.
module tb_fe_redirect_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_cond_in;
    logic [31:0] br_target_in;
    logic        stall_in;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        fe_valid;
    logic [31:0] fe_inst;
    logic [31:0] fe_pc;
    logic [31:0] fe_pcplus;
    logic [31:0] fe_inst_count;
    logic        misalign_err;
    logic [15:0] redirect_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fe_redirect_fetch_unit dut (
        .clk(clk), .reset(reset), .br_cond_in(br_cond_in), .br_target_in(br_target_in),
        .stall_in(stall_in), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .fe_valid(fe_valid), .fe_inst(fe_inst), .fe_pc(fe_pc), .fe_pcplus(fe_pcplus),
        .fe_inst_count(fe_inst_count), .misalign_err(misalign_err),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // Memory content is a recognisable function of the word address.
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return {18'h0, a} ^ 32'hA500_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pcplus;
        logic [31:0] cnt;
        logic [15:0] rcnt;
        logic        mis;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic stall,
                                input logic valid, input logic [31:0] pc,
                                input logic [31:0] pcplus, input logic [31:0] cnt,
                                input logic [15:0] rcnt, input logic mis);
        vec_t v;
        v.br = br; v.tgt = tgt; v.stall = stall; v.valid = valid; v.pc = pc;
        v.pcplus = pcplus; v.cnt = cnt; v.rcnt = rcnt; v.mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic br, input logic [31:0] tgt, input logic stall);
        br_cond_in   = br;
        br_target_in = tgt;
        stall_in     = stall;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".fe_valid"}, {31'h0, fe_valid}, 32'h0);
        check({tag, ".fe_inst"}, fe_inst, NOP);
        check({tag, ".fe_pc"}, fe_pc, 32'h0);
        check({tag, ".fe_pcplus"}, fe_pcplus, 32'h0);
        check({tag, ".fe_inst_count"}, fe_inst_count, 32'h0);
        check({tag, ".misalign_err"}, {31'h0, misalign_err}, 32'h0);
        check({tag, ".redirect_count"}, {16'h0, redirect_count}, 32'h0);
        check({tag, ".imem_addr"}, {18'h0, imem_addr}, 32'h0000_0080);
    endtask

    initial begin
        logic [31:0] exp_inst;
        logic [13:0] waddr;

        //          br  tgt            st  vld pc             pcplus         cnt rcnt mis
        vecs[0]  = mk(0, 32'h0,        0,  0, 32'h0,         32'h0,         0,  0,  0); // BOOT bubble
        vecs[1]  = mk(0, 32'h0,        0,  1, 32'h200,       32'h204,       0,  0,  0);
        vecs[2]  = mk(0, 32'h0,        0,  1, 32'h204,       32'h208,       1,  0,  0);
        vecs[3]  = mk(0, 32'h0,        1,  1, 32'h204,       32'h208,       1,  0,  0); // stall x3
        vecs[4]  = mk(0, 32'h0,        1,  1, 32'h204,       32'h208,       1,  0,  0);
        vecs[5]  = mk(0, 32'h0,        1,  1, 32'h204,       32'h208,       1,  0,  0);
        vecs[6]  = mk(0, 32'h0,        0,  1, 32'h208,       32'h20C,       2,  0,  0);
        vecs[7]  = mk(1, 32'h400,      0,  0, 32'h208,       32'h20C,       2,  1,  0); // redirect bubble
        vecs[8]  = mk(0, 32'h0,        0,  1, 32'h400,       32'h404,       3,  1,  0);
        vecs[9]  = mk(1, 32'h300,      1,  0, 32'h400,       32'h404,       3,  2,  0); // redirect beats stall
        vecs[10] = mk(0, 32'h0,        0,  1, 32'h300,       32'h304,       4,  2,  0);
        vecs[11] = mk(1, 32'h402,      0,  0, 32'h300,       32'h304,       4,  3,  1); // misaligned
        vecs[12] = mk(0, 32'h0,        0,  1, 32'h400,       32'h404,       5,  3,  1);
        vecs[13] = mk(1, 32'hFFFF_FFFC,0,  0, 32'h400,       32'h404,       5,  4,  1);
        vecs[14] = mk(0, 32'h0,        0,  1, 32'hFFFF_FFFC, 32'h0,         6,  4,  1); // PC wrap
        vecs[15] = mk(0, 32'h0,        0,  1, 32'h0,         32'h4,         7,  4,  1);
        vecs[16] = mk(0, 32'h0,        1,  1, 32'h0,         32'h4,         7,  4,  1);

        reset = 1'b1;
        br_cond_in = 1'b0;
        br_target_in = 32'h0;
        stall_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].br, vecs[i].tgt, vecs[i].stall);
            waddr    = vecs[i].pc[15:2];
            exp_inst = vecs[i].valid ? mem_word(waddr) : NOP;
            check($sformatf("v%0d.fe_valid", i), {31'h0, fe_valid}, {31'h0, vecs[i].valid});
            check($sformatf("v%0d.fe_inst", i), fe_inst, exp_inst);
            check($sformatf("v%0d.fe_pc", i), fe_pc, vecs[i].pc);
            check($sformatf("v%0d.fe_pcplus", i), fe_pcplus, vecs[i].pcplus);
            check($sformatf("v%0d.fe_inst_count", i), fe_inst_count, vecs[i].cnt);
            check($sformatf("v%0d.redirect_count", i), {16'h0, redirect_count}, {16'h0, vecs[i].rcnt});
            check($sformatf("v%0d.misalign_err", i), {31'h0, misalign_err}, {31'h0, vecs[i].mis});
        end
        // After the last vector the fetch PC sits at 0x4.
        check("after_vec.imem_addr", {18'h0, imem_addr}, 32'h1);

        // Reset asserted together with a redirect and a stall must win.
        reset = 1'b1;
        step(1'b1, 32'h0000_0802, 1'b1);
        check_reset_state("reset_mid");
        reset = 1'b0;

        // Redirect counter saturation: idle BOOT cycle, then continuous redirects.
        step(1'b0, 32'h0, 1'b0);
        br_cond_in   = 1'b1;
        br_target_in = 32'h0000_0100;
        stall_in     = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        check("sat.count_65534", {16'h0, redirect_count}, 32'h0000_FFFE);
        @(posedge clk);
        #1;
        check("sat.count_65535", {16'h0, redirect_count}, 32'h0000_FFFF);
        repeat (2) @(posedge clk);
        #1;
        check("sat.count_held", {16'h0, redirect_count}, 32'h0000_FFFF);
        check("sat.fe_valid", {31'h0, fe_valid}, 32'h0);
        check("sat.misalign_err", {31'h0, misalign_err}, 32'h0);
        check("sat.imem_addr", {18'h0, imem_addr}, 32'h0000_0040);
        step(1'b0, 32'h0, 1'b0);
        check("sat.resume_pc", fe_pc, 32'h0000_0100);
        check("sat.resume_cnt", fe_inst_count, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
